// File: rtl/hazard_detect_pkg.sv
// Shared constants and types for the ID-stage hazard unit.
// Opcodes, FSM state encoding and statistics counter width.
package hazard_detect_pkg;

    localparam int CNT_W = 16;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/hazard_detect_sat_counter.sv
// Saturating event counter with synchronous clear.
// Clear takes priority over increment.
module sat_counter
    import hazard_detect_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    // Count up on inc, stick at all-ones, clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {CNT_W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_detect.sv
// ID-stage hazard detection: stalls, branch flush, statistics.
// Load-then-branch needs two stall cycles, covered by HOLD.
module hazard_detect
    import hazard_detect_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      inst_ID,
    input  logic             read_mem_EX,
    input  logic             write_EX,
    input  logic [4:0]       write_dst_EX,
    input  logic             read_mem_MEM,
    input  logic [4:0]       write_dst_MEM,
    input  logic             branch_taken_ID,
    input  logic             clear_stats,
    output logic             pc_write,
    output logic             IF_ID_write,
    output logic             ID_EX_bubble,
    output logic             IF_ID_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic             busy
);

    logic [5:0] op;
    logic [4:0] rs_id;
    logic [4:0] rt_id;
    logic       unused_imm;

    assign op         = inst_ID[31:26];
    assign rs_id      = inst_ID[25:21];
    assign rt_id      = inst_ID[20:16];
    assign unused_imm = ^inst_ID[15:0];

    logic is_br;
    logic is_jmp;
    logic rt_src;

    assign is_br  = (op == OP_BEQ) || (op == OP_BNE);
    assign is_jmp = (op == OP_J) || (op == OP_JAL);
    assign rt_src = (op == OP_RTYPE) || is_br || (op == OP_SW);

    // $0 never creates a dependency.
    logic hit_ex;
    logic hit_mem;

    assign hit_ex =
        ((rs_id != 5'd0) && (rs_id == write_dst_EX)) ||
        (rt_src && (rt_id != 5'd0) && (rt_id == write_dst_EX));
    assign hit_mem =
        ((rs_id != 5'd0) && (rs_id == write_dst_MEM)) ||
        (rt_src && (rt_id != 5'd0) && (rt_id == write_dst_MEM));

    logic load_use;
    logic alu_br;
    logic load_br;
    logic late_br;
    logic any_hz;

    assign load_use = read_mem_EX && hit_ex && !is_br;
    assign alu_br   = is_br && write_EX && !read_mem_EX && hit_ex;
    assign load_br  = is_br && read_mem_EX && hit_ex;
    assign late_br  = is_br && read_mem_MEM && hit_mem;
    assign any_hz   = load_use || alu_br || load_br || late_br;

    state_t state;
    state_t state_n;
    logic   rem;
    logic   rem_n;
    logic   stall;
    logic   stall_g;
    logic   flush;

    // State and remaining-stall register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
            rem   <= 1'b0;
        end else begin
            state <= state_n;
            rem   <= rem_n;
        end
    end

    // Next state and Mealy stall decision.
    always_comb begin
        state_n = state;
        rem_n   = rem;
        stall   = 1'b0;
        unique case (state)
            RUN: begin
                stall = any_hz;
                if (load_br) begin
                    state_n = HOLD;
                    rem_n   = 1'b1;
                end
            end
            HOLD: begin
                stall = 1'b1;
                if (rem != 1'b0) begin
                    rem_n = rem - 1'b1;
                end
                if (rem_n == 1'b0) begin
                    state_n = RUN;
                end
            end
            default: begin
                state_n = RUN;
                rem_n   = 1'b0;
            end
        endcase
    end

    // Reset masks any combinational hazard seen on the inputs.
    assign stall_g = reset_n && stall;
    assign flush   = reset_n && !stall &&
                     ((is_br && branch_taken_ID) || is_jmp);

    assign pc_write     = !stall_g;
    assign IF_ID_write  = !stall_g;
    assign ID_EX_bubble = stall_g;
    assign IF_ID_flush  = flush;
    assign busy         = (state == HOLD);

    sat_counter u_stall_cnt (
        .clk   (clk),
        .rst_n (reset_n),
        .clr   (clear_stats),
        .inc   (stall_g),
        .q     (stall_cycles)
    );

    sat_counter u_flush_cnt (
        .clk   (clk),
        .rst_n (reset_n),
        .clr   (clear_stats),
        .inc   (flush),
        .q     (flush_count)
    );

endmodule

// File: tb/tb_hazard_detect.sv
// Bench for hazard_detect: vector table plus directed sequences.
// Expected outputs are queued on drive and popped at negedge.
module tb_hazard_detect;
    import hazard_detect_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [31:0] inst_ID;
    logic        read_mem_EX;
    logic        write_EX;
    logic [4:0]  write_dst_EX;
    logic        read_mem_MEM;
    logic [4:0]  write_dst_MEM;
    logic        branch_taken_ID;
    logic        clear_stats;
    logic        pc_write;
    logic        IF_ID_write;
    logic        ID_EX_bubble;
    logic        IF_ID_flush;
    logic [15:0] stall_cycles;
    logic [15:0] flush_count;
    logic        busy;

    hazard_detect dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .inst_ID         (inst_ID),
        .read_mem_EX     (read_mem_EX),
        .write_EX        (write_EX),
        .write_dst_EX    (write_dst_EX),
        .read_mem_MEM    (read_mem_MEM),
        .write_dst_MEM   (write_dst_MEM),
        .branch_taken_ID (branch_taken_ID),
        .clear_stats     (clear_stats),
        .pc_write        (pc_write),
        .IF_ID_write     (IF_ID_write),
        .ID_EX_bubble    (ID_EX_bubble),
        .IF_ID_flush     (IF_ID_flush),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [5:0] OP_ORI = 6'd13;

    typedef struct {
        logic [31:0] inst;
        logic        rmex;
        logic        wex;
        logic [4:0]  dex;
        logic        rmmem;
        logic [4:0]  dmem;
        logic        tk;
        logic        stall;
        logic        fl;
    } vec_t;

    // {pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, busy}
    logic [4:0] sb[$];

    int n_chk;
    int n_pass;
    logic [15:0] m_sc;
    logic [15:0] m_fc;
    vec_t tbl[14];

    function automatic logic [31:0] mk(logic [5:0] op,
                                      logic [4:0] rs,
                                      logic [4:0] rt);
        return {op, rs, rt, 16'h0024};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic drive(logic [31:0] inst, logic rmex, logic wex,
                         logic [4:0] dex, logic rmmem, logic [4:0] dmem,
                         logic tk, logic clr);
        inst_ID         = inst;
        read_mem_EX     = rmex;
        write_EX        = wex;
        write_dst_EX    = dex;
        read_mem_MEM    = rmmem;
        write_dst_MEM   = dmem;
        branch_taken_ID = tk;
        clear_stats     = clr;
    endtask

    task automatic nop_in();
        drive(32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic expect_out(logic st, logic fl, logic bz);
        sb.push_back({~st, ~st, st, fl, bz});
    endtask

    task automatic check_out(string nm);
        logic [4:0] e;
        @(negedge clk);
        if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = sb.pop_front();
            chk(nm, {27'd0, pc_write, IF_ID_write, ID_EX_bubble,
                     IF_ID_flush, busy}, {27'd0, e});
        end
    endtask

    task automatic tick(string nm, logic st, logic fl, logic clr);
        @(posedge clk);
        #1;
        if (clr) begin
            m_sc = 16'd0;
            m_fc = 16'd0;
        end else begin
            if (st && m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
            if (fl && m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
        end
        chk({nm, ".stall_cycles"}, {16'd0, stall_cycles}, {16'd0, m_sc});
        chk({nm, ".flush_count"}, {16'd0, flush_count}, {16'd0, m_fc});
    endtask

    task automatic cyc(string nm, logic st, logic fl, logic bz, logic clr);
        expect_out(st, fl, bz);
        check_out(nm);
        tick(nm, st, fl, clr);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        m_sc   = 16'd0;
        m_fc   = 16'd0;

        tbl[0]  = '{mk(OP_RTYPE, 5'd8, 5'd1), 1, 1, 5'd8, 0, 5'd0, 0, 1, 0};
        tbl[1]  = '{mk(OP_RTYPE, 5'd1, 5'd8), 1, 1, 5'd8, 0, 5'd0, 0, 1, 0};
        tbl[2]  = '{mk(OP_ORI, 5'd1, 5'd5), 1, 1, 5'd5, 0, 5'd0, 0, 0, 0};
        tbl[3]  = '{mk(OP_RTYPE, 5'd0, 5'd0), 1, 1, 5'd0, 0, 5'd0, 0, 0, 0};
        tbl[4]  = '{mk(OP_SW, 5'd1, 5'd7), 1, 1, 5'd7, 0, 5'd0, 0, 1, 0};
        tbl[5]  = '{mk(OP_BEQ, 5'd10, 5'd2), 0, 1, 5'd10, 0, 5'd0, 1, 1, 0};
        tbl[6]  = '{mk(OP_BEQ, 5'd10, 5'd2), 0, 0, 5'd10, 0, 5'd0, 1, 0, 1};
        tbl[7]  = '{mk(OP_BNE, 5'd3, 5'd4), 0, 0, 5'd0, 1, 5'd4, 1, 1, 0};
        tbl[8]  = '{mk(OP_RTYPE, 5'd4, 5'd1), 0, 0, 5'd0, 1, 5'd4, 0, 0, 0};
        tbl[9]  = '{mk(OP_J, 5'd6, 5'd6), 0, 0, 5'd0, 0, 5'd0, 0, 0, 1};
        tbl[10] = '{mk(OP_JAL, 5'd8, 5'd2), 1, 1, 5'd8, 0, 5'd0, 0, 1, 0};
        tbl[11] = '{mk(OP_BEQ, 5'd1, 5'd2), 0, 1, 5'd9, 0, 5'd0, 0, 0, 0};
        tbl[12] = '{mk(OP_LW, 5'd6, 5'd3), 0, 1, 5'd6, 0, 5'd0, 0, 0, 0};
        tbl[13] = '{mk(OP_BEQ, 5'd0, 5'd0), 0, 1, 5'd0, 0, 5'd0, 1, 0, 1};

        // Reset: a live load-use hazard on the inputs must be masked.
        reset_n = 1'b0;
        drive(mk(OP_RTYPE, 5'd8, 5'd1), 1'b1, 1'b1, 5'd8,
              1'b0, 5'd0, 1'b1, 1'b0);
        expect_out(1'b0, 1'b0, 1'b0);
        check_out("reset_outputs");
        chk("reset.stall_cycles", {16'd0, stall_cycles}, 32'd0);
        chk("reset.flush_count", {16'd0, flush_count}, 32'd0);
        #1;
        nop_in();
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].inst, tbl[i].rmex, tbl[i].wex, tbl[i].dex,
                  tbl[i].rmmem, tbl[i].dmem, tbl[i].tk, 1'b0);
            cyc($sformatf("vec%0d", i), tbl[i].stall, tbl[i].fl,
                1'b0, 1'b0);
        end

        // Load-branch: RUN stall then one HOLD cycle, taken ignored.
        nop_in();
        clear_stats = 1'b1;
        cyc("lb_clear", 1'b0, 1'b0, 1'b0, 1'b1);
        drive(mk(OP_BEQ, 5'd1, 5'd9), 1'b1, 1'b1, 5'd9,
              1'b0, 5'd0, 1'b1, 1'b0);
        cyc("lb_run", 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("lb_hold", 1'b1, 1'b0, 1'b1, 1'b0);
        drive(mk(OP_BEQ, 5'd1, 5'd9), 1'b0, 1'b0, 5'd0,
              1'b0, 5'd0, 1'b1, 1'b0);
        cyc("lb_resolve", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("lb.stall_total", {16'd0, stall_cycles}, 32'd2);

        // ALU-branch stall, then taken branch flushes once.
        nop_in();
        clear_stats = 1'b1;
        cyc("ab_clear", 1'b0, 1'b0, 1'b0, 1'b1);
        drive(mk(OP_BNE, 5'd10, 5'd3), 1'b0, 1'b1, 5'd10,
              1'b0, 5'd0, 1'b0, 1'b0);
        cyc("ab_stall", 1'b1, 1'b0, 1'b0, 1'b0);
        drive(mk(OP_BNE, 5'd10, 5'd3), 1'b0, 1'b0, 5'd0,
              1'b0, 5'd0, 1'b1, 1'b0);
        cyc("ab_flush", 1'b0, 1'b1, 1'b0, 1'b0);
        nop_in();
        cyc("ab_after", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ab.flush_total", {16'd0, flush_count}, 32'd1);

        // Reset asserted in the middle of HOLD.
        drive(mk(OP_BNE, 5'd9, 5'd2), 1'b1, 1'b1, 5'd9,
              1'b0, 5'd0, 1'b0, 1'b0);
        cyc("rh_run", 1'b1, 1'b0, 1'b0, 1'b0);
        expect_out(1'b1, 1'b0, 1'b1);
        check_out("rh_hold");
        #1;
        reset_n = 1'b0;
        #1;
        m_sc = 16'd0;
        m_fc = 16'd0;
        chk("rh.busy", {31'd0, busy}, 32'd0);
        chk("rh.pc_write", {31'd0, pc_write}, 32'd1);
        chk("rh.bubble", {31'd0, ID_EX_bubble}, 32'd0);
        chk("rh.stall_cycles", {16'd0, stall_cycles}, 32'd0);
        chk("rh.flush_count", {16'd0, flush_count}, 32'd0);
        nop_in();
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        drive(mk(OP_RTYPE, 5'd8, 5'd1), 1'b1, 1'b1, 5'd8,
              1'b0, 5'd0, 1'b0, 1'b0);
        cyc("rh_resume", 1'b1, 1'b0, 1'b0, 1'b0);
        nop_in();
        cyc("rh_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Saturation, then clear beats a simultaneous stall.
        clear_stats = 1'b1;
        cyc("sat_clear", 1'b0, 1'b0, 1'b0, 1'b1);
        drive(mk(OP_RTYPE, 5'd8, 5'd1), 1'b1, 1'b1, 5'd8,
              1'b0, 5'd0, 1'b0, 1'b0);
        repeat (65534) @(posedge clk);
        #1;
        chk("sat.near", {16'd0, stall_cycles}, 32'h0000FFFE);
        repeat (2) @(posedge clk);
        #1;
        chk("sat.hold", {16'd0, stall_cycles}, 32'h0000FFFF);
        m_sc = 16'hFFFF;
        clear_stats = 1'b1;
        cyc("sat_clr_win", 1'b1, 1'b0, 1'b0, 1'b1);
        chk("sat.cleared", {16'd0, stall_cycles}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
